// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle sequencer: states, instruction classes, opcodes, mux selects.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_RST    = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_DECODE = 3'd2;
  localparam state_t ST_EXEC   = 3'd3;
  localparam state_t ST_MEM    = 3'd4;
  localparam state_t ST_WB     = 3'd5;
  localparam state_t ST_TRAP   = 3'd6;
  localparam state_t ST_HOLD   = 3'd7;

  typedef enum logic [3:0] {
    CL_R, CL_IALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_LUI, CL_AUIPC
  } instr_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic SRC_RS1  = 1'b0;
  localparam logic SRC_PC   = 1'b1;
  localparam logic SRC_RS2  = 1'b0;
  localparam logic SRC_IMM  = 1'b1;
  localparam logic PC_PLUS4 = 1'b0;
  localparam logic PC_ALU   = 1'b1;

endpackage

// File: rtl/instr_class_dec.sv
// Opcode-to-instruction-class decoder with an illegal-opcode flag.
// Latency: combinational.
// Backpressure: none.
module instr_class_dec
  import ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_t cls,
  output logic         illegal
);

  always_comb begin
    cls     = CL_R;
    illegal = 1'b0;
    case (opcode)
      OP_R:      cls = CL_R;
      OP_IALU:   cls = CL_IALU;
      OP_LOAD:   cls = CL_LOAD;
      OP_STORE:  cls = CL_STORE;
      OP_BRANCH: cls = CL_BRANCH;
      OP_JAL:    cls = CL_JAL;
      OP_JALR:   cls = CL_JALR;
      OP_LUI:    cls = CL_LUI;
      OP_AUIPC:  cls = CL_AUIPC;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer; SINGLE_STEP_EN adds a step-gated HOLD state.
// Latency: R 4, BRANCH 3, LOAD 5, STORE 4 cycles with zero-wait ack.
// Backpressure: mem_req held until mem_ack; ACK_TIMEOUT unacked cycles traps (0 disables).
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        op1_src,
  output logic        op2_src,
  output logic        alu_funct,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        halt,
  output logic [2:0]  state
);

`ifdef SINGLE_STEP_EN
  localparam state_t FETCH_ENTRY = ST_HOLD;
`else
  localparam state_t FETCH_ENTRY = ST_FETCH;
`endif

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  state_t          state_q, state_nxt;
  instr_class_t    cls_q, cls_dec;
  logic            illegal;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            unused_instr_hi;

  assign unused_instr_hi = ^instr[31:7];

  instr_class_dec u_dec (
    .opcode  (instr[6:0]),
    .cls     (cls_dec),
    .illegal (illegal)
  );

  // The limit is hit on the waiting cycle that brings the count to ACK_TIMEOUT; an ack that cycle wins.
  assign to_hit = (ACK_TIMEOUT != 0) && (to_cnt == TO_LAST) && mem_req && !mem_ack;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_RST:    state_nxt = FETCH_ENTRY;
      ST_FETCH: begin
        if (mem_ack)     state_nxt = ST_DECODE;
        else if (to_hit) state_nxt = ST_TRAP;
      end
      ST_DECODE: state_nxt = illegal ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        if (cls_q == CL_BRANCH)                          state_nxt = FETCH_ENTRY;
        else if (cls_q == CL_LOAD || cls_q == CL_STORE)  state_nxt = ST_MEM;
        else                                             state_nxt = ST_WB;
      end
      ST_MEM: begin
        if (mem_ack)     state_nxt = (cls_q == CL_STORE) ? FETCH_ENTRY : ST_WB;
        else if (to_hit) state_nxt = ST_TRAP;
      end
      ST_WB:     state_nxt = FETCH_ENTRY;
      ST_TRAP:   state_nxt = ST_TRAP;
`ifdef SINGLE_STEP_EN
      ST_HOLD:   if (step) state_nxt = ST_FETCH;
`endif
      default:   state_nxt = ST_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      cls_q   <= CL_R;
      to_cnt  <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == ST_DECODE) cls_q <= cls_dec;
      if (state_nxt != state_q)        to_cnt <= '0;
      else if (mem_req && !mem_ack)    to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_PLUS4;
    op1_src      = SRC_RS1;
    op2_src      = SRC_RS2;
    alu_funct    = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    halt         = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
      end
      ST_EXEC: begin
        case (cls_q)
          CL_R:      alu_funct = 1'b1;
          CL_IALU: begin
            op2_src   = SRC_IMM;
            alu_funct = 1'b1;
          end
          CL_LOAD, CL_STORE, CL_JALR: op2_src = SRC_IMM;
          CL_AUIPC, CL_JAL: begin
            op1_src = SRC_PC;
            op2_src = SRC_IMM;
          end
          CL_BRANCH: begin
            op1_src = SRC_PC;
            op2_src = SRC_IMM;
            pc_we   = 1'b1;
            pc_src  = branch_taken ? PC_ALU : PC_PLUS4;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == CL_STORE);
        op2_src      = SRC_IMM;
        pc_we        = mem_ack && (cls_q == CL_STORE);
      end
      ST_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        pc_src = (cls_q == CL_JAL || cls_q == CL_JALR) ? PC_ALU : PC_PLUS4;
        case (cls_q)
          CL_LOAD:          wb_sel = WB_MEM;
          CL_JAL, CL_JALR:  wb_sel = WB_PC4;
          CL_LUI:           wb_sel = WB_IMM;
          default:          wb_sel = WB_ALU;
        endcase
      end
      ST_TRAP:   halt = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, random instruction stream vs. a per-instruction trace model,
// plus timeout, illegal-opcode and asynchronous-reset corner sequences.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int ACK_TO = 16;
  localparam int K_R = 0, K_IALU = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4,
                 K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        branch_taken = 1'b0;
  logic        mem_ack = 1'b0;
`ifdef SINGLE_STEP_EN
  logic        step = 1'b1;
`endif
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src;
  logic        op1_src, op2_src, alu_funct, rf_we, halt;
  logic [1:0]  wb_sel;
  logic [2:0]  state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.ACK_TIMEOUT(ACK_TO), .TO_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef SINGLE_STEP_EN
    .step         (step),
`endif
    .instr        (instr),
    .branch_taken (branch_taken),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .op1_src      (op1_src),
    .op2_src      (op2_src),
    .alu_funct    (alu_funct),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .halt         (halt),
    .state        (state)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ack;
    logic        bt;
    logic [31:0] ins;
    logic [2:0]  st;
    logic [12:0] o;
  } cyc_t;
  cyc_t plan_q[$];

  typedef struct {
    logic [31:0] ins;
    int          fw, mw;
    logic        bt;
    int          cyc, pcwe, pcsrc, rfwe, wbs;
  } vec_t;
  vec_t tv[10];

  logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] outs_now();
    return {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, op1_src, op2_src,
            alu_funct, rf_we, wb_sel, halt};
  endfunction

  function automatic logic [12:0] mk(input logic req, we, asel, irwe, pcwe, pcsrc,
                                     op1, op2, af, rfwe, input logic [1:0] wbs, input logic hlt);
    return {req, we, asel, irwe, pcwe, pcsrc, op1, op2, af, rfwe, wbs, hlt};
  endfunction

  function automatic int opclass(input logic [31:0] w);
    case (w[6:0])
      7'h33: return K_R;
      7'h13: return K_IALU;
      7'h03: return K_LOAD;
      7'h23: return K_STORE;
      7'h63: return K_BR;
      7'h6F: return K_JAL;
      7'h67: return K_JALR;
      7'h37: return K_LUI;
      7'h17: return K_AUIPC;
      default: return -1;
    endcase
  endfunction

  task automatic push(input logic ack, input logic bt, input logic [31:0] ins,
                      input logic [2:0] st, input logic [12:0] o);
    cyc_t r;
    r.ack = ack; r.bt = bt; r.ins = ins; r.st = st; r.o = o;
    plan_q.push_back(r);
  endtask

  // Expected per-cycle trace of one instruction; mw >= ACK_TO means the data ack never comes.
  task automatic plan_instr(input logic [31:0] ins, input int fw, input int mw, input logic bt, input bit noise);
    int c = opclass(ins);
    logic st, op1, op2, af;
    logic [1:0] wbs;
    for (int i = 0; i < fw; i++) push(1'b0, bt, ins, ST_FETCH, mk(1,0,0,0,0,0,0,0,0,0,2'd0,0));
    push(1'b1, bt, ins, ST_FETCH, mk(1,0,0,1,0,0,0,0,0,0,2'd0,0));
    push(noise & 1'($urandom_range(0,1)), bt, ins, ST_DECODE, 13'd0);
    if (c < 0) begin
      for (int i = 0; i < 4; i++)
        push(noise & 1'($urandom_range(0,1)), bt, ins, ST_TRAP, mk(0,0,0,0,0,0,0,0,0,0,2'd0,1));
      return;
    end
    op1 = c inside {K_AUIPC, K_JAL, K_BR};
    op2 = !(c inside {K_R, K_LUI});
    af  = c inside {K_R, K_IALU};
    push(noise & 1'($urandom_range(0,1)), bt, ins, ST_EXEC,
         mk(0,0,0,0, c == K_BR, (c == K_BR) && bt, op1, op2, af, 0, 2'd0, 0));
    if (c == K_BR) return;
    if (c == K_LOAD || c == K_STORE) begin
      st = (c == K_STORE);
      for (int i = 0; i < ((mw >= ACK_TO) ? ACK_TO : mw); i++)
        push(1'b0, bt, ins, ST_MEM, mk(1, st, 1, 0, 0, 0, 0, 1, 0, 0, 2'd0, 0));
      if (mw >= ACK_TO) begin
        for (int i = 0; i < 4; i++)
          push(noise & 1'($urandom_range(0,1)), bt, ins, ST_TRAP, mk(0,0,0,0,0,0,0,0,0,0,2'd0,1));
        return;
      end
      push(1'b1, bt, ins, ST_MEM, mk(1, st, 1, 0, st, 0, 0, 1, 0, 0, 2'd0, 0));
      if (st) return;
    end
    wbs = (c == K_LOAD) ? 2'd1 : (c == K_JAL || c == K_JALR) ? 2'd2 : (c == K_LUI) ? 2'd3 : 2'd0;
    push(noise & 1'($urandom_range(0,1)), bt, ins, ST_WB,
         mk(0,0,0,0,1, c == K_JAL || c == K_JALR, 0,0,0,1, wbs, 0));
  endtask

  // Entered just after a rising edge; leaves just after the edge following the last planned cycle.
  task automatic run_plan(input string tag, output int len, output int pcwe_n, output int pcsrc_v,
                          output int rfwe_n, output int wbsel_v);
    int k = 0;
    len = plan_q.size(); pcwe_n = 0; pcsrc_v = 0; rfwe_n = 0; wbsel_v = 0;
    while (plan_q.size() > 0) begin
      cyc_t r;
      r = plan_q.pop_front();
      #1;
      mem_ack = r.ack; branch_taken = r.bt; instr = r.ins;
      #3;
      check($sformatf("%s c%0d state", tag, k), 32'(state), 32'(r.st));
      check($sformatf("%s c%0d outs", tag, k), 32'(outs_now()), 32'(r.o));
      if (pc_we) begin pcwe_n++; pcsrc_v = int'(pc_src); end
      if (rf_we) begin rfwe_n++; wbsel_v = int'(wb_sel); end
      k++;
      @(posedge clk);
    end
    #1 mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0; mem_ack = 1'b0;
    #1 check("rst state", 32'(state), 32'(ST_RST));
    check("rst outs", 32'(outs_now()), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    int len, pw, ps, rw, ws;
    logic [31:0] rnd;

    tv[0] = '{32'h002081B3, 0, 0, 1'b0, 4, 1, 0, 1, 0};
    tv[1] = '{32'h00208463, 0, 0, 1'b1, 3, 1, 1, 0, 0};
    tv[2] = '{32'h00208463, 0, 0, 1'b0, 3, 1, 0, 0, 0};
    tv[3] = '{32'h0040A283, 0, 3, 1'b0, 8, 1, 0, 1, 1};
    tv[4] = '{32'h0020A223, 0, 0, 1'b0, 4, 1, 0, 0, 0};
    tv[5] = '{32'h008000EF, 0, 0, 1'b0, 4, 1, 1, 1, 2};
    tv[6] = '{32'h123452B7, 0, 0, 1'b0, 4, 1, 0, 1, 3};
    tv[7] = '{32'h00001297, 0, 0, 1'b0, 4, 1, 0, 1, 0};
    tv[8] = '{32'h000080E7, 0, 0, 1'b1, 4, 1, 1, 1, 2};
    tv[9] = '{32'h00108093, 2, 0, 1'b0, 6, 1, 0, 1, 0};

    #2 check("por state", 32'(state), 32'(ST_RST));
    check("por outs", 32'(outs_now()), 32'd0);
    @(posedge clk);
    #1 check("rst held", 32'(state), 32'(ST_RST));
    rst_n = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 10; i++) begin
      plan_instr(tv[i].ins, tv[i].fw, tv[i].mw, tv[i].bt, 1'b0);
      run_plan($sformatf("vec%0d", i), len, pw, ps, rw, ws);
      check($sformatf("vec%0d cycles", i), 32'(len), 32'(tv[i].cyc));
      check($sformatf("vec%0d pc_we cnt", i), 32'(pw), 32'(tv[i].pcwe));
      check($sformatf("vec%0d pc_src", i), 32'(ps), 32'(tv[i].pcsrc));
      check($sformatf("vec%0d rf_we cnt", i), 32'(rw), 32'(tv[i].rfwe));
      check($sformatf("vec%0d wb_sel", i), 32'(ws), 32'(tv[i].wbs));
    end

    for (int i = 0; i < 40; i++) begin
      rnd = $urandom();
      plan_instr({rnd[31:7], ops[$urandom_range(0, 8)]}, $urandom_range(0, 3),
                 $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b1);
      run_plan($sformatf("rnd%0d", i), len, pw, ps, rw, ws);
    end

    // Store whose ack lands in the last allowed MEM cycle completes normally.
    plan_instr(32'h0020A223, 0, ACK_TO - 1, 1'b0, 1'b0);
    run_plan("sw late ack", len, pw, ps, rw, ws);
    check("sw late ack pc_we", 32'(pw), 32'd1);
    plan_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);
    run_plan("after late ack", len, pw, ps, rw, ws);

    // Store never acked traps after ACK_TO cycles in MEM; halt stays up.
    plan_instr(32'h0020A223, 1, ACK_TO, 1'b0, 1'b1);
    run_plan("sw timeout", len, pw, ps, rw, ws);
    check("sw timeout pc_we", 32'(pw), 32'd0);
    repeat (5) @(posedge clk);
    #1 check("halt sticky", 32'(halt), 32'd1);
    check("trap mem_req", 32'(mem_req), 32'd0);
    do_reset();

    // Illegal opcode: decode then trap, no architectural strobes.
    plan_instr(32'hFFFFFFFF, 0, 0, 1'b0, 1'b1);
    run_plan("illegal", len, pw, ps, rw, ws);
    check("illegal pc_we", 32'(pw), 32'd0);
    check("illegal rf_we", 32'(rw), 32'd0);
    check("illegal halt", 32'(halt), 32'd1);
    do_reset();

    // Asynchronous reset in the middle of a load's data transfer.
    plan_instr(32'h0040A283, 0, 5, 1'b0, 1'b0);
    while (plan_q.size() > 4) void'(plan_q.pop_back());
    run_plan("lw pre-rst", len, pw, ps, rw, ws);
    #1 check("mid-mem req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1 check("async rst req", 32'(mem_req), 32'd0);
    check("async rst state", 32'(state), 32'(ST_RST));
    check("async rst outs", 32'(outs_now()), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check("post-rst state", 32'(state), 32'(ST_FETCH));
    check("post-rst addr_sel", 32'(mem_addr_sel), 32'd0);
    check("post-rst req", 32'(mem_req), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
